// File: rtl/tone_period_decoder.sv
`timescale 1ns/1ps
// Purpose : measures the rising-edge period of an asynchronous square wave, locks once stable, flags silence.
// Latency : edge pulse 3 cycles after an iSOUND rise; outputs registered one cycle after the deciding edge.
// Backpressure: none, free-running observer; optional note classifier enabled by `define TONE_DEC_NOTE_EN.
module tone_period_decoder #(
    parameter int CNT_W      = 18,
    parameter int TIMEOUT    = 262143,
    parameter int MIN_PERIOD = 1000,
    parameter int STABLE_N   = 2,
    parameter int TOL_SH     = 6
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    input  logic             iSOUND,
    output logic [CNT_W-1:0] oPERIOD,
    output logic             oVALID,
    output logic             oLOCKED,
    output logic             oSILENT,
    output logic [3:0]       oNOTE
);

    localparam int MC_W = (STABLE_N < 1) ? 1 : $clog2(STABLE_N + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);
    localparam logic [MC_W-1:0]  STABLE_C  = MC_W'(STABLE_N);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MEASURE = 2'd1,
        S_LOCKED  = 2'd2
    } state_t;

    // synchronizer / edge detector
    logic sync1_q, sync2_q, sync3_q, edge_q;

    // measurement state
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] prev_q, prev_d;
    logic             prev_vld_q, prev_vld_d;
    logic [MC_W-1:0]  match_q, match_d;
    logic [MC_W-1:0]  match_inc;

    // registered outputs
    logic [CNT_W-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             locked_q, locked_d;
    logic             silent_q, silent_d;

    // decision helpers
    logic             timeout_w;
    logic             acc_edge_w;
    logic             is_match_w;
    logic [CNT_W:0]   p_ext, prev_ext, diff_w, tol_w;

    // two-flop synchronizer, then a registered rising-edge pulse
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= iSOUND;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            edge_q  <= sync2_q & ~sync3_q;
        end
    end

    // Tolerance compare in one extra bit so the difference never wraps.
    assign p_ext     = {1'b0, cnt_q};
    assign prev_ext  = {1'b0, prev_q};
    assign diff_w    = (p_ext >= prev_ext) ? (p_ext - prev_ext) : (prev_ext - p_ext);
    assign tol_w     = prev_ext >> TOL_SH;
    assign is_match_w = prev_vld_q && (diff_w <= tol_w);
    assign match_inc = match_q + MC_W'(1);

    // Silence only counts once a tone has started; in IDLE the counter just saturates.
    assign timeout_w  = (state_q != S_IDLE) && (cnt_q == TIMEOUT_C);
    // Short intervals are glitches, except the very first edge which has no reference.
    assign acc_edge_w = edge_q && ((state_q == S_IDLE) || (cnt_q >= MIN_C));

    // next-state and output decisions
    always_comb begin
        state_d    = state_q;
        cnt_d      = (cnt_q >= TIMEOUT_C) ? TIMEOUT_C : (cnt_q + ONE_C);
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
        match_d    = match_q;
        period_d   = period_q;
        valid_d    = 1'b0;

        if (timeout_w) begin
            // Timeout beats a coincident edge; that edge then restarts measurement.
            state_d    = S_IDLE;
            period_d   = '0;
            prev_d     = '0;
            prev_vld_d = 1'b0;
            match_d    = '0;
            if (edge_q) begin
                state_d = S_MEASURE;
                cnt_d   = ONE_C;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (edge_q) begin
                        state_d    = S_MEASURE;
                        cnt_d      = ONE_C;
                        prev_vld_d = 1'b0;
                        match_d    = '0;
                    end
                end
                S_MEASURE: begin
                    if (acc_edge_w) begin
                        cnt_d      = ONE_C;
                        prev_d     = cnt_q;
                        prev_vld_d = 1'b1;
                        if (!prev_vld_q) begin
                            match_d = '0;
                        end else if (is_match_w) begin
                            match_d = match_inc;
                            if (match_inc >= STABLE_C) begin
                                state_d  = S_LOCKED;
                                period_d = cnt_q;
                                valid_d  = 1'b1;
                            end
                        end else begin
                            match_d = '0;
                        end
                    end
                end
                S_LOCKED: begin
                    if (acc_edge_w) begin
                        cnt_d  = ONE_C;
                        prev_d = cnt_q;
                        if (is_match_w) begin
                            period_d = cnt_q;
                        end else begin
                            // Period held so downstream still sees the last good tone.
                            state_d = S_MEASURE;
                            match_d = '0;
                        end
                    end
                end
                default: begin
                    state_d    = S_IDLE;
                    prev_vld_d = 1'b0;
                    match_d    = '0;
                end
            endcase
        end

        locked_d = (state_d == S_LOCKED);
        silent_d = (state_d == S_IDLE);
    end

    // state, counters and registered outputs
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            match_q    <= '0;
            period_q   <= '0;
            valid_q    <= 1'b0;
            locked_q   <= 1'b0;
            silent_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
            match_q    <= match_d;
            period_q   <= period_d;
            valid_q    <= valid_d;
            locked_q   <= locked_d;
            silent_q   <= silent_d;
        end
    end

    assign oPERIOD = period_q;
    assign oVALID  = valid_q;
    assign oLOCKED = locked_q;
    assign oSILENT = silent_q;

`ifdef TONE_DEC_NOTE_EN
    // C4..C5 periods in 50 MHz clock cycles
    localparam logic [31:0] NOTE_TAB [8] = '{
        32'd191113, 32'd170265, 32'd151685, 32'd143172,
        32'd127551, 32'd113636, 32'd101239, 32'd95557
    };

    logic [3:0] note_q, note_d;

    // First table entry within tolerance wins; scanning downward lets the lowest index overwrite.
    function automatic logic [3:0] classify(input logic [CNT_W-1:0] p);
        logic [31:0] pv, t, d;
        logic [3:0]  idx;
        pv  = 32'(p);
        idx = 4'hF;
        for (int i = 7; i >= 0; i--) begin
            t = NOTE_TAB[i];
            d = (pv >= t) ? (pv - t) : (t - pv);
            if (d <= (t >> TOL_SH)) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

    // note follows the period that will be presented next cycle
    always_comb begin
        note_d = 4'hF;
        if (locked_d) begin
            note_d = classify(period_d);
        end
    end

    // note register, aligned with oPERIOD
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            note_q <= 4'hF;
        end else begin
            note_q <= note_d;
        end
    end

    assign oNOTE = note_q;
`else
    assign oNOTE = 4'hF;
`endif

endmodule
